// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - two-requester round-robin register-file write arbiter
// Register 0 writes are accepted but dropped, and counted in zero_drops.
module regfile_write_arbiter #(
  parameter int DW = 32,
  parameter int AW = 5,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_valid,
  input  logic [AW-1:0] req0_reg,
  input  logic [DW-1:0] req0_data,
  output logic          req0_ready,
  input  logic          req1_valid,
  input  logic [AW-1:0] req1_reg,
  input  logic [DW-1:0] req1_data,
  output logic          req1_ready,
  output logic          RegWrite,
  output logic [AW-1:0] write_reg,
  output logic [DW-1:0] write_data,
  output logic          last_grant,
  output logic [CW-1:0] zero_drops
);

  logic          ptr;
  logic          grant0;
  logic          grant1;
  logic          accept;
  logic [AW-1:0] sel_reg;
  logic [DW-1:0] sel_data;
  logic          sel_zero;

  // ptr names the requester that wins when both are valid
  always_comb begin
    grant0   = req0_valid && (!req1_valid || !ptr);
    grant1   = req1_valid && (!req0_valid ||  ptr);
    accept   = grant0 || grant1;
    sel_reg  = grant1 ? req1_reg  : req0_reg;
    sel_data = grant1 ? req1_data : req0_data;
    sel_zero = (sel_reg == '0);
  end

  assign req0_ready = grant0 && !rst;
  assign req1_ready = grant1 && !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr        <= 1'b0;
      RegWrite   <= 1'b0;
      write_reg  <= '0;
      write_data <= '0;
      last_grant <= 1'b0;
      zero_drops <= '0;
    end else begin
      RegWrite <= accept && !sel_zero;
      if (accept) begin
        ptr        <= !grant1;
        last_grant <= grant1;
        if (!sel_zero) begin
          write_reg  <= sel_reg;
          write_data <= sel_data;
        end else if (zero_drops != {CW{1'b1}}) begin
          zero_drops <= zero_drops + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - randomized and directed bench against a behavioural arbiter model
module tb_regfile_write_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic [4:0]  req0_reg = '0, req1_reg = '0;
  logic [31:0] req0_data = '0, req1_data = '0;
  logic        req0_ready, req1_ready;
  logic        RegWrite;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic        last_grant;
  logic [7:0]  zero_drops;

  int n_checks = 0;
  int n_fail   = 0;

  // model state
  int          prio;
  int          last_g;
  bit          m_rw;
  int          m_reg;
  longint      m_data;
  int          m_lg;
  int          m_zd;

  regfile_write_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_reg(req0_reg), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_reg(req1_reg), .req1_data(req1_data), .req1_ready(req1_ready),
    .RegWrite(RegWrite), .write_reg(write_reg), .write_data(write_data),
    .last_grant(last_grant), .zero_drops(zero_drops)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    prio = 0; last_g = -1; m_rw = 0; m_reg = 0; m_data = 0; m_lg = 0; m_zd = 0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".RegWrite"},   RegWrite,   m_rw);
    check({tag, ".write_reg"},  write_reg,  m_reg);
    check({tag, ".write_data"}, write_data, m_data);
    check({tag, ".last_grant"}, last_grant, m_lg);
    check({tag, ".zero_drops"}, zero_drops, m_zd);
  endtask

  // called at a falling edge: drive, check readies, advance one cycle, check outputs
  task automatic step(input bit v0, input int r0, input longint d0,
                      input bit v1, input int r1, input longint d1);
    int     g;
    int     r;
    longint d;
    req0_valid = v0; req0_reg = 5'(r0); req0_data = 32'(d0);
    req1_valid = v1; req1_reg = 5'(r1); req1_data = 32'(d1);
    #1;
    if (v0 && v1)  g = prio;
    else if (v0)   g = 0;
    else if (v1)   g = 1;
    else           g = -1;
    check("req0_ready", req0_ready, g == 0);
    check("req1_ready", req1_ready, g == 1);
    m_rw = 0;
    if (g >= 0) begin
      r = (g == 1) ? r1 : r0;
      d = (g == 1) ? d1 : d0;
      m_lg = g;
      prio = 1 - g;
      if (r != 0) begin
        m_rw = 1; m_reg = r; m_data = d;
      end else if (m_zd < 255) begin
        m_zd++;
      end
    end
    last_g = g;
    @(posedge clk);
    @(negedge clk);
    check_outputs("step");
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    check("rst.req0_ready", req0_ready, 0);
    check("rst.req1_ready", req1_ready, 0);
    model_reset();
    @(negedge clk);
    check_outputs("rst");
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst = 1'b0;
  endtask

  bit     p0, p1;
  int     pr0, pr1;
  longint pd0, pd1;

  initial begin
    model_reset();
    do_reset();

    // both requesters continuously: alternation 0,1,0,1
    for (int i = 0; i < 4; i++) begin
      step(1, 3, 'hA, 1, 4, 'hB);
      check("alt.grant", last_g, i % 2);
      check("alt.write_reg", write_reg, (i % 2) ? 4 : 3);
      check("alt.RegWrite", RegWrite, 1);
    end

    // single req1 write, then idle
    step(0, 0, 0, 1, 7, 'h1234);
    check("single.write_reg", write_reg, 7);
    check("single.write_data", write_data, 'h1234);
    step(0, 0, 0, 0, 0, 0);
    check("single.idle", RegWrite, 0);

    // zero-register accepts are counted, never written
    for (int i = 0; i < 3; i++) step(1, 0, 'hFF, 0, 0, 0);
    check("zero.count", zero_drops, 3);
    check("zero.write_reg_held", write_reg, 7);
    check("zero.write_data_held", write_data, 'h1234);
    for (int i = 0; i < 297; i++) step(i % 2, 0, i, (i + 1) % 2, 0, i);
    check("zero.saturate", zero_drops, 255);

    // same register from both: 0x1 then 0x2
    do_reset();
    step(1, 5, 'h1, 1, 5, 'h2);
    check("same.first", write_data, 'h1);
    step(0, 0, 0, 1, 5, 'h2);
    check("same.second", write_data, 'h2);

    // randomized traffic with held-until-accepted requests
    p0 = 0; p1 = 0; pr0 = 0; pr1 = 0; pd0 = 0; pd1 = 0;
    for (int i = 0; i < 500; i++) begin
      if (!p0 && ($urandom_range(0, 2) != 0)) begin
        p0 = 1; pr0 = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 31); pd0 = $urandom;
      end
      if (!p1 && ($urandom_range(0, 2) != 0)) begin
        p1 = 1; pr1 = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 31); pd1 = $urandom;
      end
      step(p0, pr0, pd0, p1, pr1, pd1);
      if (last_g == 0) p0 = 0;
      if (last_g == 1) p1 = 0;
    end

    // asynchronous reset between an accept edge and the next edge
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b1; req1_reg = 5'd9; req1_data = 32'h55;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst.RegWrite", RegWrite, 0);
    check("arst.write_reg", write_reg, 0);
    check("arst.write_data", write_data, 0);
    model_reset();
    @(negedge clk);
    req1_valid = 1'b0;
    rst = 1'b0;
    step(0, 0, 0, 0, 0, 0);
    check("arst.no_write", RegWrite, 0);
    step(1, 6, 'h66, 1, 8, 'h88);
    check("arst.first_grant", last_g, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
